// File: rtl/apb_pkg.sv
// apb_reg_slave shared types and constants.
// State encoding, word shift and default ID word.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam int APB_WORD_SHIFT = 2;

  localparam logic [31:0] APB_ID_DEFAULT = 32'hA5B0_0001;

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB3 bus bundle between the bridge (master)
// and the register completer (slave).
interface apb_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  PSEL;
  logic                  PENABLE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR,
    output PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR,
    input  PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter with zero flag,
// used to pace APB wait states.
module apb_wait_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load wins; otherwise count down, saturating at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/apb_reg_slave.sv
// APB3 register-bank completer with ID word at index 0.
// APB_SLAVE_WAIT_EN enables WAIT_CYCLES wait states.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int WAIT_CYCLES = 2,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE =
    DATA_WIDTH'(APB_ID_DEFAULT)
) (
  input logic           PCLK,
  input logic           PRESETn,
  apb_reg_slave_if.slave bus
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int XW = ADDR_WIDTH - APB_WORD_SHIFT;

  apb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [XW-1:0] idx_full;
  logic [IW-1:0] idx;
  logic          err;
  logic          access;
  logic          ready;
  logic          cnt_zero;

  assign idx_full = addr_q[ADDR_WIDTH-1:APB_WORD_SHIFT];
  assign idx      = idx_full[IW-1:0];
  assign access   = (state_q == ACCESS);
  assign ready    = access & cnt_zero;

  // misaligned, out of range, or write to the ID word
  assign err = (addr_q[1:0] != 2'b00)
             | (idx_full >= XW'(NUM_REGS))
             | (write_q & (idx_full == '0));

`ifdef APB_SLAVE_WAIT_EN
  apb_wait_ctr #(.W(4)) u_ctr (
    .clk      (PCLK),
    .rst_n    (PRESETn),
    .load     (state_q == SETUP),
    .load_val (4'(WAIT_CYCLES)),
    .dec      (access),
    .zero     (cnt_zero)
  );
`else
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);
  assign cnt_zero    = 1'b1;
`endif

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready & err;

  // read data only on a clean read completion
  always_comb begin
    bus.PRDATA = '0;
    if (ready && !write_q && !err) begin
      bus.PRDATA = (idx == '0) ? ID_VALUE : regs[idx];
    end
  end

  // transfer FSM, request latch and register file
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.PSEL && !bus.PENABLE) begin
            state_q <= SETUP;
          end
        end
        SETUP: begin
          addr_q  <= bus.PADDR;
          write_q <= bus.PWRITE;
          wdata_q <= bus.PWDATA;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (ready) begin
            if (write_q && !err) begin
              regs[idx] <= wdata_q;
            end
            if (bus.PSEL && !bus.PENABLE) begin
              state_q <= SETUP;
            end else begin
              state_q <= IDLE;
            end
          end else if (!bus.PSEL) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
